// File: rtl/cpu_trace_monitor.sv
// Circular execution-trace buffer snooping core fetch/store strobes, with PC-match trigger
// and oldest-first drain. Store capture is compiled in only when TRACE_STORE_EN is defined.
module cpu_trace_monitor #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int TS_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        PC,
   input  logic [DATA_W-1:0]        ReadData,
   input  logic                     IRWrite,
   input  logic [ADDR_W-1:0]        Adr,
   input  logic [DATA_W-1:0]        WriteData,
   input  logic                     MemWrite,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     trig_en,
   input  logic [ADDR_W-1:0]        trig_pc,
   input  logic [$clog2(DEPTH):0]   post_len,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic                     rd_kind,
   output logic [ADDR_W-1:0]        rd_addr,
   output logic [DATA_W-1:0]        rd_data,
   output logic [TS_W-1:0]          rd_ts,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     frozen,
   output logic                     overflow,
   output logic                     lost
);

   // state  | meaning
   // IDLE   | after reset, nothing captured
   // RUN    | capturing, PC trigger armed
   // POST   | capturing the post-trigger window
   // FROZEN | capture stopped, buffer drains through rd_*

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_POST,
      ST_FROZEN
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [CNT_W-1:0]   post_cnt_q, post_cnt_d;
   logic [TS_W-1:0]    ts_q, ts_d;
   logic               overflow_q, overflow_d;
   logic               lost_q, lost_d;

   logic [ADDR_W-1:0]  mem_addr_q [DEPTH];
   logic [DATA_W-1:0]  mem_data_q [DEPTH];
   logic [TS_W-1:0]    mem_ts_q   [DEPTH];

   logic               fetch_ev;
   logic               store_ev;
   logic               capture;
   logic               full;
   logic               is_frozen;
   logic               avail;
   logic [ADDR_W-1:0]  wr_addr;
   logic [DATA_W-1:0]  wr_data;

   assign fetch_ev  = IRWrite;
   assign full      = (count_q == CNT_W'(DEPTH));
   assign is_frozen = (state_q == ST_FROZEN);
   assign avail     = is_frozen && (count_q != '0);

`ifdef TRACE_STORE_EN
   logic               wr_kind;
   logic               mem_kind_q [DEPTH];

   // A fetch always wins the single write slot; a coincident store is the one dropped.
   assign store_ev = MemWrite;
   assign wr_kind  = ~fetch_ev;
   assign wr_addr  = fetch_ev ? PC : Adr;
   assign wr_data  = fetch_ev ? ReadData : WriteData;

   always_ff @(posedge clk) begin
      if (capture) begin
         mem_kind_q[wr_ptr_q] <= wr_kind;
      end
   end

   assign rd_kind = avail ? mem_kind_q[rd_ptr_q] : 1'b0;
`else
   logic               unused_store;

   assign store_ev     = 1'b0;
   assign wr_addr      = PC;
   assign wr_data      = ReadData;
   assign unused_store = ^{MemWrite, Adr, WriteData};
   assign rd_kind      = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      post_cnt_d = post_cnt_q;
      overflow_d = overflow_q;
      lost_d     = lost_q;
      ts_d       = ts_q + 1'b1;
      capture    = 1'b0;

      if (start) begin
         state_d    = ST_RUN;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         post_cnt_d = '0;
         overflow_d = 1'b0;
         lost_d     = 1'b0;
         ts_d       = '0;
      end else begin
         case (state_q)
            ST_RUN, ST_POST: begin
               capture = fetch_ev | store_ev;
               if (fetch_ev && store_ev) begin
                  lost_d = 1'b1;
               end
               if (capture) begin
                  wr_ptr_d = wr_ptr_q + 1'b1;
                  // Full buffer: overwrite the oldest entry and slide the read pointer past it.
                  if (full) begin
                     rd_ptr_d   = rd_ptr_q + 1'b1;
                     overflow_d = 1'b1;
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end
               if (state_q == ST_RUN) begin
                  if (fetch_ev && trig_en && (PC == trig_pc)) begin
                     if (post_len == '0) begin
                        state_d = ST_FROZEN;
                     end else begin
                        post_cnt_d = post_len;
                        state_d    = ST_POST;
                     end
                  end
               end else if (capture) begin
                  post_cnt_d = post_cnt_q - 1'b1;
                  if (post_cnt_q == CNT_W'(1)) begin
                     state_d = ST_FROZEN;
                  end
               end
               if (stop) begin
                  state_d = ST_FROZEN;
               end
            end
            ST_FROZEN: begin
               if (avail && rd_ready) begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
                  count_d  = count_q - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         post_cnt_q <= '0;
         ts_q       <= '0;
         overflow_q <= 1'b0;
         lost_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         post_cnt_q <= post_cnt_d;
         ts_q       <= ts_d;
         overflow_q <= overflow_d;
         lost_q     <= lost_d;
      end
   end

   // Entry storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (capture) begin
         mem_addr_q[wr_ptr_q] <= wr_addr;
         mem_data_q[wr_ptr_q] <= wr_data;
         mem_ts_q[wr_ptr_q]   <= ts_q;
      end
   end

   assign rd_valid = avail;
   assign rd_addr  = avail ? mem_addr_q[rd_ptr_q] : '0;
   assign rd_data  = avail ? mem_data_q[rd_ptr_q] : '0;
   assign rd_ts    = avail ? mem_ts_q[rd_ptr_q]   : '0;
   assign count    = count_q;
   assign frozen   = is_frozen;
   assign overflow = overflow_q;
   assign lost     = lost_q;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Self-checking bench for cpu_trace_monitor: vector table for basic capture plus
// hand-written sequences, with captured entries tracked in a scoreboard queue.
module tb_cpu_trace_monitor;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int TS_W   = 16;
   localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef TRACE_STORE_EN
   localparam bit STORE_EN = 1'b1;
`else
   localparam bit STORE_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] PC;
   logic [DATA_W-1:0] ReadData;
   logic              IRWrite;
   logic [ADDR_W-1:0] Adr;
   logic [DATA_W-1:0] WriteData;
   logic              MemWrite;
   logic              start;
   logic              stop;
   logic              trig_en;
   logic [ADDR_W-1:0] trig_pc;
   logic [CNT_W-1:0]  post_len;
   logic              rd_valid;
   logic              rd_ready;
   logic              rd_kind;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic [TS_W-1:0]   rd_ts;
   logic [CNT_W-1:0]  count;
   logic              frozen;
   logic              overflow;
   logic              lost;

   always #5 clk = ~clk;

   cpu_trace_monitor #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TS_W(TS_W)
   ) dut (
      .clk(clk), .reset(reset), .PC(PC), .ReadData(ReadData), .IRWrite(IRWrite),
      .Adr(Adr), .WriteData(WriteData), .MemWrite(MemWrite), .start(start), .stop(stop),
      .trig_en(trig_en), .trig_pc(trig_pc), .post_len(post_len), .rd_valid(rd_valid),
      .rd_ready(rd_ready), .rd_kind(rd_kind), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_ts(rd_ts), .count(count), .frozen(frozen), .overflow(overflow), .lost(lost)
   );

   typedef struct {
      logic              kind;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [TS_W-1:0]   ts;
   } entry_t;

   typedef struct {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
      int                exp_count;
   } vec_t;

   entry_t          exp_q[$];
   logic [TS_W-1:0] ts_m;
   int              n_chk  = 0;
   int              n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Advance one clock; the timestamp model follows the same clear/increment rule.
   task automatic tick();
      @(posedge clk);
      if (reset || start) ts_m = '0;
      else ts_m = ts_m + 1'b1;
      #1;
   endtask

   task automatic push_exp(input logic kind, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
      entry_t e;
      e.kind = kind; e.addr = a; e.data = d; e.ts = ts_m;
      if (exp_q.size() == DEPTH) void'(exp_q.pop_front());
      exp_q.push_back(e);
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] pc, input logic [DATA_W-1:0] instr,
                        input bit captured);
      PC = pc; ReadData = instr; IRWrite = 1'b1;
      if (captured) push_exp(1'b0, pc, instr);
      tick();
      IRWrite = 1'b0;
   endtask

   task automatic pulse_start();
      exp_q.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_count"},    count,    0);
      chk({tag, "_rd_valid"}, rd_valid, 0);
      chk({tag, "_frozen"},   frozen,   0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_lost"},     lost,     0);
      chk({tag, "_rd_kind"},  rd_kind,  0);
      chk({tag, "_rd_addr"},  rd_addr,  0);
      chk({tag, "_rd_data"},  rd_data,  0);
      chk({tag, "_rd_ts"},    rd_ts,    0);
   endtask

   // Drain until the scoreboard is empty, optionally stalling rd_ready first.
   task automatic drain(input int stall, output logic [ADDR_W-1:0] first_a,
                        output logic [ADDR_W-1:0] last_a);
      int  n = exp_q.size() + stall;
      bit  first = 1'b1;
      first_a = '0;
      last_a  = '0;
      for (int i = 0; i < n; i++) begin
         chk("drain_valid", rd_valid, 1);
         chk("drain_kind",  rd_kind,  exp_q[0].kind);
         chk("drain_addr",  rd_addr,  exp_q[0].addr);
         chk("drain_data",  rd_data,  exp_q[0].data);
         chk("drain_ts",    rd_ts,    exp_q[0].ts);
         if (first) first_a = rd_addr;
         first  = 1'b0;
         last_a = rd_addr;
         if (stall > 0) begin
            stall--;
            rd_ready = 1'b0;
            tick();
            chk("stall_count", count, exp_q.size());
         end else begin
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            void'(exp_q.pop_front());
            chk("pop_count", count, exp_q.size());
         end
      end
      chk("empty_valid",  rd_valid, 0);
      chk("empty_addr",   rd_addr,  0);
      chk("empty_frozen", frozen,   1);
   endtask

   task automatic trig_run(input logic [ADDR_W-1:0] tpc, input logic [CNT_W-1:0] plen,
                           input logic [ADDR_W-1:0] last_pc);
      logic [ADDR_W-1:0] fa, la;
      trig_en = 1'b1; trig_pc = tpc; post_len = plen;
      pulse_start();
      chk("trig_ovf_cleared", overflow, 0);
      for (int pc = 0; pc < 'h40; pc += 4) begin
         fetch(ADDR_W'(pc), $urandom, ADDR_W'(pc) <= last_pc);
         chk("trig_frozen", frozen, ADDR_W'(pc) >= last_pc);
      end
      trig_en = 1'b0;
      chk("trig_count", count, last_pc / 4 + 1);
      drain(0, fa, la);
      chk("trig_first_pc", fa, 0);
      chk("trig_last_pc",  la, last_pc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t              vecs [3];
      logic [ADDR_W-1:0] fa, la;

      vecs[0] = '{32'h00, 32'hE04F000F, 1};
      vecs[1] = '{32'h04, 32'hE2802005, 2};
      vecs[2] = '{32'h08, 32'hE2803000, 3};

      reset = 1'b1; PC = '0; ReadData = '0; IRWrite = 1'b0; Adr = '0; WriteData = '0;
      MemWrite = 1'b0; start = 1'b0; stop = 1'b0; trig_en = 1'b0; trig_pc = '0;
      post_len = '0; rd_ready = 1'b0; ts_m = '0;
      tick();
      tick();
      reset = 1'b0;
      chk_reset_outs("reset");

      fetch(32'h100, 32'h1111, 1'b0);
      chk("idle_no_capture", count, 0);

      // Basic capture from the vector table, then a stalled drain.
      pulse_start();
      for (int i = 0; i < 3; i++) begin
         fetch(vecs[i].pc, vecs[i].instr, 1'b1);
         chk("t1_count",  count,  vecs[i].exp_count);
         chk("t1_frozen", frozen, 0);
         chk("t1_rd_valid_running", rd_valid, 0);
      end
      pulse_stop();
      chk("t1_frozen_after_stop", frozen, 1);
      chk("t1_count_after_stop",  count,  3);
      chk("t1_overflow",          overflow, 0);
      drain(3, fa, la);
      chk("t1_first_pc", fa, 32'h00);
      chk("t1_last_pc",  la, 32'h08);

      // Overflow: 20 fetches into 16 entries, stop coinciding with the last fetch.
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         if (i == 19) stop = 1'b1;
         fetch(ADDR_W'(i * 4), $urandom, 1'b1);
         stop = 1'b0;
      end
      chk("ovf_flag",   overflow, 1);
      chk("ovf_count",  count,    16);
      chk("ovf_frozen", frozen,   1);
      drain(0, fa, la);
      chk("ovf_first_pc", fa, 32'h10);
      chk("ovf_last_pc",  la, 32'h4C);

      // PC trigger with and without a post-trigger window.
      trig_run(32'h20, 2, 32'h28);
      trig_run(32'h08, 0, 32'h08);

      // Stores, including a store colliding with a fetch.
      pulse_start();
      fetch(32'h00, 32'hE3A00001, 1'b1);
      MemWrite = 1'b1; Adr = 32'h64; WriteData = 32'h7;
      if (STORE_EN) push_exp(1'b1, 32'h64, 32'h7);
      tick();
      MemWrite = 1'b0;
      chk("st_count_after_store", count, STORE_EN ? 2 : 1);
      chk("st_lost_clear", lost, 0);
      fetch(32'h04, 32'hE5801000, 1'b1);
      MemWrite = 1'b1; Adr = 32'h68; WriteData = 32'h9;
      fetch(32'h08, 32'hE2811001, 1'b1);
      MemWrite = 1'b0;
      chk("st_lost", lost, STORE_EN ? 1 : 0);
      pulse_stop();
      chk("st_count", count, STORE_EN ? 4 : 3);
      chk("st_overflow", overflow, 0);
      drain(0, fa, la);
      chk("st_last_pc", la, 32'h08);

      // Reset in the middle of a drain.
      pulse_start();
      for (int i = 0; i < 4; i++) fetch(ADDR_W'(32'h200 + i * 4), $urandom, 1'b1);
      pulse_stop();
      chk("rst_pre_addr", rd_addr, 32'h200);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      void'(exp_q.pop_front());
      chk("rst_pre_count", count, 3);
      chk("rst_next_addr", rd_addr, 32'h204);
      reset = 1'b1;
      tick();
      chk_reset_outs("mid_reset");
      reset = 1'b0;
      exp_q.delete();
      fetch(32'h300, 32'h3333, 1'b0);
      chk("post_reset_idle", count, 0);

      // start beats a simultaneous fetch and stop; timestamp restarts from zero.
      pulse_start();
      fetch(32'h10, 32'hAAAA, 1'b1);
      fetch(32'h14, 32'hBBBB, 1'b1);
      pulse_stop();
      chk("ss_pre_count", count, 2);
      exp_q.delete();
      start = 1'b1; stop = 1'b1; PC = 32'h40; ReadData = 32'hCCCC; IRWrite = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0; IRWrite = 1'b0;
      chk("ss_count",    count,    0);
      chk("ss_frozen",   frozen,   0);
      chk("ss_rd_valid", rd_valid, 0);
      fetch(32'h44, 32'hDDDD, 1'b1);
      chk("ss_count_run", count, 1);
      pulse_stop();
      drain(0, fa, la);
      chk("ss_last_pc", la, 32'h44);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Parametrised on-chip execution trace buffer for the multi-cycle ARM core. It snoops the core's fetch and store strobes and records each fetched instruction, and optionally each data store, as a timestamped entry in a circular buffer. It supports a PC-match trigger with a programmable post-trigger window, then freezes and drains oldest-first over a valid/ready port. It sits beside `top`, wired to the core/memory interface, and replaces ad-hoc simulation `$display` tracing with a synthesisable, bench-readable history.

## Interface
Parameters:
- `ADDR_W`, 32, PC/address width
- `DATA_W`, 32, instruction/store data width
- `DEPTH`, 16, buffer entries; power of two, ≥2
- `TS_W`, 16, timestamp width

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high
- `PC`  in  ADDR_W  address of the fetch in progress
- `ReadData`  in  DATA_W  memory read data; holds the instruction word while `IRWrite`=1
- `IRWrite`  in  1  fetch strobe (instruction latched this cycle)
- `Adr`  in  ADDR_W  memory address
- `WriteData`  in  DATA_W  store data
- `MemWrite`  in  1  store strobe
- `start`  in  1  pulse: clear buffer, begin capture
- `stop`  in  1  pulse: freeze immediately
- `trig_en`  in  1  enable PC-match trigger
- `trig_pc`  in  ADDR_W  trigger address
- `post_len`  in  $clog2(DEPTH)+1  records captured after the trigger record
- `rd_valid`  out  1  entry available
- `rd_ready`  in  1  consumer accepts entry
- `rd_kind`  out  1  0=fetch, 1=store
- `rd_addr`  out  ADDR_W  PC or store address
- `rd_data`  out  DATA_W  instruction or store data
- `rd_ts`  out  TS_W  timestamp of capture
- `count`  out  $clog2(DEPTH)+1  valid entries
- `frozen`  out  1  in FROZEN state
- `overflow`  out  1  sticky: an entry was overwritten
- `lost`  out  1  sticky: a simultaneous store was dropped

## Operation
- States: IDLE (reset) → RUN → POST → FROZEN.
- IDLE: no capture. `start` → RUN.
- RUN/POST capture: event on `IRWrite` writes {0, `PC`, `ReadData`, ts}; on `MemWrite` writes {1, `Adr`, `WriteData`, ts}. At most one entry per cycle.
- Both strobes in one cycle: fetch entry written, store dropped, `lost` set.
- Full buffer on capture: oldest entry overwritten, read pointer advances, `count` stays `DEPTH`, `overflow` set.
- RUN: fetch entry with `trig_en`=1 and `PC`==`trig_pc` is written. With `post_len`=0, go to FROZEN. Otherwise load the post counter with `post_len` and go to POST. Store entries never trigger.
- POST: each captured entry decrements the counter; the entry that brings it to 0 is written, then go to FROZEN.
- `stop` in RUN/POST: go to FROZEN. An event in the same cycle is still captured.
- FROZEN: no capture. `rd_*` shows the entry at the read pointer (oldest). `rd_valid` = (`count`≠0). `rd_valid`&`rd_ready` pops one entry. Stays FROZEN when empty.
- `start` in any state: pointers, `count`, `overflow`, `lost`, ts cleared; go to RUN. An event in the same cycle is not captured. `start` has priority over `stop`.
- Timestamp: free-running TS_W counter, incremented every cycle, wraps modulo 2^TS_W, cleared on `reset`/`start`.

## Timing
- Reset values: state IDLE, `count`=0, `rd_valid`=0, `frozen`=0, `overflow`=0, `lost`=0, ts=0, `rd_kind`/`rd_addr`/`rd_data`/`rd_ts`=0.
- Event sampled at edge N: `count` and flags reflect it after edge N. The entry's ts is the counter value before edge N.
- Freeze decided at edge N: `frozen`=1 and `rd_valid` (if `count`≠0) valid after edge N.
- `rd_*` is combinational from buffer and read pointer, and forced to 0 when `rd_valid`=0. A pop at edge N presents the next entry after edge N. Throughput is 1 entry/cycle.
- Reset mid-operation discards everything. Storage contents need no reset.

## Configuration
- `TRACE_STORE_EN` defined: store entries captured as above, `lost` functional.
- Undefined: `MemWrite`/`Adr`/`WriteData` ignored, `rd_kind` tied 0, `lost` tied 0, and stores never consume entries.

## Test plan
- Reset then `start`; 3 fetches at PC 0x00, 0x04, 0x08 with instr 0xE04F000F, 0xE2802005, 0xE2803000; `stop` → `count`=3, drain yields those pairs in order with increasing ts, then `rd_valid`=0.
- DEPTH=16, 20 fetches PC 0x00..0x4C, then `stop` → `overflow`=1, `count`=16, first drained PC 0x10, last 0x4C.
- `trig_pc`=0x20, `post_len`=2, fetches PC 0x00.. step 4 → freeze after the 0x28 entry; later fetches ignored; last drained PC 0x28.
- With `TRACE_STORE_EN`: store Adr 0x64, data 0x00000007 between fetches → `rd_kind`=1 entry in order. `IRWrite` and `MemWrite` in the same cycle → only the fetch recorded, `lost`=1.
- `rd_ready` held low 3 cycles then high → `rd_*` stable while stalled, one pop per ready cycle. `reset` asserted mid-drain → all outputs at reset values next cycle.
- `start` in the same cycle as `IRWrite` and `stop` → RUN with `count`=0, `frozen`=0.
